spi_mul_sequencer: RTL
======================

# spi_mul_sequencer

Transaction sequencer between the SPI engine (`spi_master_slave`) and the 16x16 multiplier core. On each `go` it runs two SPI receive transactions for operand A then operand B, starts the multiplier, and returns the 32-bit product as two SPI transmit transactions: high word first, then low word. The sequencer owns every start strobe and the clock-divider select of the SPI engine. It is the single point that decides when the shared SPI link is busy.

## Interface
- `TIMEOUT_CYCLES`, default 65535: per-phase watchdog limit in `clk` cycles. Used only with `SEQ_TIMEOUT_EN`.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `go`  in  1  single-cycle request to run one frame. Sampled only in IDLE.
- `cfg_freq`  in  2  SPI clock-divider select. Latched into `freq_control` on an accepted `go`.
- `spi_rx_start`  out  1  single-cycle pulse to the SPI engine (`slave_rx_start`).
- `spi_tx_start`  out  1  single-cycle pulse to the SPI engine (`slave_tx_start`).
- `spi_tx_data`  out  16  word to transmit (`miso_reg_data`). Held stable for the whole TX phase.
- `freq_control`  out  2  divider select to the SPI engine.
- `spi_rx_data`  in  16  received word (`mosi_reg_data`).
- `spi_rx_valid`  in  1  receive complete (`rx_valid`).
- `spi_tx_done`  in  1  transmit complete (`tx_done`).
- `mul_a`, `mul_b`  out  16  operand registers.
- `mul_start`  out  1  single-cycle multiplier start.
- `mul_product`  in  32  multiplier result. Valid when `mul_done` is high.
- `mul_done`  in  1  multiplier completion.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  single-cycle pulse when a frame completes without error.
- `error`  out  1  sticky timeout flag. Cleared on the next accepted `go`.
- `frame_count`  out  8  count of completed frames. Wraps 255 -> 0.

## Operation
- States: IDLE, RX_A, RX_B, MUL, TX_HI, TX_LO, DONE.
- IDLE
  - `go` = 1 -> RX_A.
  - On the same edge: latch `cfg_freq`, clear `error`, reset the watchdog.
- Entry action on every non-IDLE, non-DONE state: on the first cycle in the state, pulse the matching strobe exactly once.
  - RX_A, RX_B: `spi_rx_start`.
  - MUL: `mul_start`.
  - TX_HI, TX_LO: `spi_tx_start`.
- Completion flags are detected on their rising edge (registered previous value), so a level-held `spi_rx_valid` or `spi_tx_done` from the previous phase cannot advance the FSM. A rising edge in the entry cycle is ignored.
- RX_A: on the `spi_rx_valid` rise, `mul_a <= spi_rx_data` -> RX_B.
- RX_B: on the `spi_rx_valid` rise, `mul_b <= spi_rx_data` -> MUL.
- MUL: on `mul_done`, capture `mul_product` into an internal 32-bit register -> TX_HI.
- TX_HI
  - `spi_tx_data` = product[31:16].
  - On the `spi_tx_done` rise -> TX_LO.
- TX_LO
  - `spi_tx_data` = product[15:0].
  - On the `spi_tx_done` rise -> DONE.
- DONE, one cycle:
  - pulse `frame_done`;
  - `frame_count` <= `frame_count` + 1 (mod 256);
  - -> IDLE.
- `go` while `busy`: ignored, not queued.
- `cfg_freq` changes while `busy`: no effect until the next accepted `go`. `freq_control` never changes mid-frame.
- Operands and product are unsigned. No truncation: product[31:0] is transmitted in full.

## Timing
- Reset (asynchronous assert, synchronous release), all of the following are zero and the state is IDLE:
  - `busy`, `error`, `frame_done`;
  - all strobes;
  - `mul_a`, `mul_b`, `spi_tx_data`;
  - `frame_count`, the product register;
  - `freq_control` = 2'b00.
- Reset asserted mid-frame aborts immediately. No strobe is issued after release until the next `go`.
- Strobe latency:
  - `go` at edge N -> `spi_rx_start` high during cycle N+1.
  - Each completion edge at edge M -> the next phase's strobe is high during cycle M+1.
- `busy` rises on the edge that accepts `go` and falls on the edge that leaves DONE.
- `frame_done` and the `frame_count` increment occur in the same cycle.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - A 16-bit watchdog counts cycles spent in any phase state and clears on every state change.
  - When the count reaches `TIMEOUT_CYCLES`: set `error`, go to IDLE, no `frame_done`, `frame_count` unchanged.
  - If a completion and the timeout occur in the same cycle, the completion wins.
- `SEQ_TIMEOUT_EN` undefined: no watchdog logic, `error` is tied to 0, and the FSM waits indefinitely in each phase.

## Test plan
- Basic frame: slave sends A=16'h1234, B=16'h5678; multiplier model returns after 4 cycles -> `spi_tx_data` is 16'h0626 then 16'h0060; `frame_done` pulses once; `frame_count`=1.
- Max operands: A=B=16'hFFFF -> TX words 16'hFFFE then 16'h0001.
- `go` pulsed during RX_B, and `cfg_freq` changed 2'b01->2'b11 mid-frame -> no second frame starts; `freq_control` stays 2'b01 until the next `go`.
- Level-held `spi_rx_valid` across the RX_A->RX_B boundary -> RX_B does not complete until a fresh rising edge; `mul_b` takes the second word.
- Reset asserted during TX_HI -> all outputs 0 on the same cycle; the next `go` runs a clean frame.
- `SEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES`=100, `mul_done` never asserted -> `error`=1 exactly 100 cycles after MUL entry, FSM back in IDLE, `frame_count` unchanged; the next `go` clears `error`.

Source files
------------

// File: rtl/spi_mul_sequencer.sv
// Sequences one SPI frame: receive A, receive B, multiply, transmit product high then low word.
// Optional watchdog on every phase is enabled by defining SEQ_TIMEOUT_EN.
`timescale 1ns/1ps
module spi_mul_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic [1:0]  cfg_freq,
  output logic        spi_rx_start,
  output logic        spi_tx_start,
  output logic [15:0] spi_tx_data,
  output logic [1:0]  freq_control,
  input  logic [15:0] spi_rx_data,
  input  logic        spi_rx_valid,
  input  logic        spi_tx_done,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  output logic        mul_start,
  input  logic [31:0] mul_product,
  input  logic        mul_done,
  output logic        busy,
  output logic        frame_done,
  output logic        error,
  output logic [7:0]  frame_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_RX_A, S_RX_B, S_MUL, S_TX_HI, S_TX_LO, S_DONE
  } state_t;

  state_t      state_reg, state_next;
  logic        first_reg;
  logic        rx_valid_prev_reg, tx_done_prev_reg;
  logic [15:0] mul_a_reg, mul_a_next;
  logic [15:0] mul_b_reg, mul_b_next;
  logic [31:0] product_reg, product_next;
  logic [15:0] tx_data_reg, tx_data_next;
  logic [1:0]  freq_reg, freq_next;
  logic [7:0]  count_reg, count_next;
  logic        error_reg, error_next;
  logic        rx_rise, tx_rise, in_phase;

  // Completion edges are ignored in the entry cycle so stale levels cannot advance the FSM.
  assign rx_rise  = spi_rx_valid & ~rx_valid_prev_reg & ~first_reg;
  assign tx_rise  = spi_tx_done  & ~tx_done_prev_reg  & ~first_reg;
  assign in_phase = (state_reg != S_IDLE) && (state_reg != S_DONE);

`ifdef SEQ_TIMEOUT_EN
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_reg, wd_next;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_next   = state_reg;
    mul_a_next   = mul_a_reg;
    mul_b_next   = mul_b_reg;
    product_next = product_reg;
    tx_data_next = tx_data_reg;
    freq_next    = freq_reg;
    count_next   = count_reg;
    error_next   = error_reg;
    case (state_reg)
      S_IDLE: begin
        if (go) begin
          state_next = S_RX_A;
          freq_next  = cfg_freq;
          error_next = 1'b0;
        end
      end
      S_RX_A: begin
        if (rx_rise) begin
          mul_a_next = spi_rx_data;
          state_next = S_RX_B;
        end
      end
      S_RX_B: begin
        if (rx_rise) begin
          mul_b_next = spi_rx_data;
          state_next = S_MUL;
        end
      end
      S_MUL: begin
        if (mul_done && !first_reg) begin
          product_next = mul_product;
          tx_data_next = mul_product[31:16];
          state_next   = S_TX_HI;
        end
      end
      S_TX_HI: begin
        if (tx_rise) begin
          tx_data_next = product_reg[15:0];
          state_next   = S_TX_LO;
        end
      end
      S_TX_LO: begin
        if (tx_rise) begin
          count_next = count_reg + 8'd1;
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
`ifdef SEQ_TIMEOUT_EN
    // A completion seen in the same cycle as the limit takes priority.
    if (in_phase && (state_next == state_reg) && (wd_reg == WD_LIMIT)) begin
      state_next = S_IDLE;
      error_next = 1'b1;
    end
    wd_next = (in_phase && (state_next == state_reg)) ? wd_reg + 16'd1 : 16'd0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg         <= S_IDLE;
      first_reg         <= 1'b0;
      rx_valid_prev_reg <= 1'b0;
      tx_done_prev_reg  <= 1'b0;
      mul_a_reg         <= '0;
      mul_b_reg         <= '0;
      product_reg       <= '0;
      tx_data_reg       <= '0;
      freq_reg          <= 2'b00;
      count_reg         <= '0;
      error_reg         <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      wd_reg            <= '0;
`endif
    end else begin
      state_reg         <= state_next;
      first_reg         <= (state_next != state_reg);
      rx_valid_prev_reg <= spi_rx_valid;
      tx_done_prev_reg  <= spi_tx_done;
      mul_a_reg         <= mul_a_next;
      mul_b_reg         <= mul_b_next;
      product_reg       <= product_next;
      tx_data_reg       <= tx_data_next;
      freq_reg          <= freq_next;
      count_reg         <= count_next;
      error_reg         <= error_next;
`ifdef SEQ_TIMEOUT_EN
      wd_reg            <= wd_next;
`endif
    end
  end

  assign spi_rx_start = first_reg && ((state_reg == S_RX_A) || (state_reg == S_RX_B));
  assign mul_start    = first_reg && (state_reg == S_MUL);
  assign spi_tx_start = first_reg && ((state_reg == S_TX_HI) || (state_reg == S_TX_LO));
  assign spi_tx_data  = tx_data_reg;
  assign freq_control = freq_reg;
  assign mul_a        = mul_a_reg;
  assign mul_b        = mul_b_reg;
  assign busy         = (state_reg != S_IDLE);
  assign frame_done   = (state_reg == S_DONE);
  assign frame_count  = count_reg;
`ifdef SEQ_TIMEOUT_EN
  assign error        = error_reg;
`else
  assign error        = 1'b0;
`endif

endmodule
